// File: rtl/bp_pkg.sv
// Shared encodings and the 2-bit saturating counter update used by every
// branch predictor table.
package bp_pkg;

  localparam int MODE_BIMODAL    = 0;
  localparam int MODE_GSHARE     = 1;
  localparam int MODE_TOURNAMENT = 2;

  // Components start weakly not-taken; the chooser starts weakly favouring gshare.
  localparam logic [1:0] COMP_RST_VAL    = 2'b01;
  localparam logic [1:0] CHOOSER_RST_VAL = 2'b10;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/tournament_bp_if.sv
// Fetch-side and EX-side signals between the pipeline and the branch predictor.
interface tournament_bp_if #(
  parameter int HIST_BITS = 8
);
  logic                 branch_en_F;
  logic                 stall_F;
  logic [31:0]          PC_F;
  logic                 BP_decision_F;
  logic [HIST_BITS-1:0] ghr_snap_F;
  logic                 branch_en_EX;
  logic [31:0]          PC_EX;
  logic                 branch_result;
  logic                 BP_decision_EX;
  logic [HIST_BITS-1:0] ghr_snap_EX;
  logic                 mispredict_EX;
  logic [31:0]          branch_count;
  logic [31:0]          mispredict_count;

  modport master (
    output branch_en_F, stall_F, PC_F, branch_en_EX, PC_EX, branch_result,
           BP_decision_EX, ghr_snap_EX,
    input  BP_decision_F, ghr_snap_F, mispredict_EX, branch_count, mispredict_count
  );

  modport slave (
    input  branch_en_F, stall_F, PC_F, branch_en_EX, PC_EX, branch_result,
           BP_decision_EX, ghr_snap_EX,
    output BP_decision_F, ghr_snap_F, mispredict_EX, branch_count, mispredict_count
  );
endinterface

// File: rtl/bp_counter_table.sv
// Table of 2-bit counters: two combinational read ports (fetch, EX), one
// write port applied at the clock edge, asynchronous reset to RST_VAL.
module bp_counter_table #(
  parameter int         INDEX_BITS = 8,
  parameter logic [1:0] RST_VAL    = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx_f,
  output logic [1:0]            rd_data_f,
  input  logic [INDEX_BITS-1:0] rd_idx_ex,
  output logic [1:0]            rd_data_ex,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [1:0]            wr_data
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0] mem [ENTRIES];

  assign rd_data_f  = mem[rd_idx_f];
  assign rd_data_ex = mem[rd_idx_ex];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= RST_VAL;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/tournament_bp.sv
// Bimodal / gshare / tournament conditional branch predictor with a
// speculatively updated global history register and performance counters.
module tournament_bp
  import bp_pkg::*;
#(
  parameter int MODE       = MODE_TOURNAMENT,
  parameter int INDEX_BITS = 8,
  parameter int HIST_BITS  = 8
) (
  input  logic          clk,
  input  logic          rst,
  tournament_bp_if.slave bp
);

  logic [INDEX_BITS-1:0] bim_idx_f, bim_idx_ex, gsh_idx_f, gsh_idx_ex;
  logic [INDEX_BITS-1:0] hist_f, hist_ex;
  logic [HIST_BITS-1:0]  ghr, ghr_shift, ghr_repair;
  logic [1:0]            bim_f, bim_ex, gsh_f, gsh_ex, cho_f, cho_ex;
  logic                  pred_raw, pred_f, mispredict;

  always_comb begin
    hist_f                   = '0;
    hist_f[HIST_BITS-1:0]    = ghr;
    hist_ex                  = '0;
    hist_ex[HIST_BITS-1:0]   = bp.ghr_snap_EX;
  end

  assign bim_idx_f  = bp.PC_F[INDEX_BITS+1:2];
  assign bim_idx_ex = bp.PC_EX[INDEX_BITS+1:2];
  assign gsh_idx_f  = bim_idx_f ^ hist_f;
  assign gsh_idx_ex = bim_idx_ex ^ hist_ex;

  if (MODE != MODE_GSHARE) begin : g_bim
    bp_counter_table #(.INDEX_BITS(INDEX_BITS), .RST_VAL(COMP_RST_VAL)) u_table (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_f  (bim_idx_f),
      .rd_data_f (bim_f),
      .rd_idx_ex (bim_idx_ex),
      .rd_data_ex(bim_ex),
      .wr_en     (bp.branch_en_EX),
      .wr_idx    (bim_idx_ex),
      .wr_data   (sat_update(bim_ex, bp.branch_result))
    );
  end else begin : g_no_bim
    assign bim_f  = 2'b00;
    assign bim_ex = 2'b00;
  end

  if (MODE != MODE_BIMODAL) begin : g_gsh
    bp_counter_table #(.INDEX_BITS(INDEX_BITS), .RST_VAL(COMP_RST_VAL)) u_table (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_f  (gsh_idx_f),
      .rd_data_f (gsh_f),
      .rd_idx_ex (gsh_idx_ex),
      .rd_data_ex(gsh_ex),
      .wr_en     (bp.branch_en_EX),
      .wr_idx    (gsh_idx_ex),
      .wr_data   (sat_update(gsh_ex, bp.branch_result))
    );
  end else begin : g_no_gsh
    assign gsh_f  = 2'b00;
    assign gsh_ex = 2'b00;
  end

  // Chooser learns only from branches where the two components disagreed.
  if (MODE == MODE_TOURNAMENT) begin : g_cho
    bp_counter_table #(.INDEX_BITS(INDEX_BITS), .RST_VAL(CHOOSER_RST_VAL)) u_table (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_f  (bim_idx_f),
      .rd_data_f (cho_f),
      .rd_idx_ex (bim_idx_ex),
      .rd_data_ex(cho_ex),
      .wr_en     (bp.branch_en_EX && (bim_ex[1] != gsh_ex[1])),
      .wr_idx    (bim_idx_ex),
      .wr_data   (sat_update(cho_ex, gsh_ex[1] == bp.branch_result))
    );
  end else begin : g_no_cho
    assign cho_f  = 2'b00;
    assign cho_ex = 2'b00;
  end

  always_comb begin
    pred_raw = bim_f[1];
    if (MODE == MODE_GSHARE)          pred_raw = gsh_f[1];
    else if (MODE == MODE_TOURNAMENT) pred_raw = cho_f[1] ? gsh_f[1] : bim_f[1];
  end

  assign pred_f     = bp.branch_en_F && !rst && pred_raw;
  assign mispredict = bp.branch_en_EX && (bp.branch_result != bp.BP_decision_EX);

  if (HIST_BITS == 1) begin : g_hist1
    assign ghr_shift  = pred_f;
    assign ghr_repair = bp.branch_result;
  end else begin : g_histn
    assign ghr_shift  = {ghr[HIST_BITS-2:0], pred_f};
    assign ghr_repair = {bp.ghr_snap_EX[HIST_BITS-2:0], bp.branch_result};
  end

  // A resolved mispredict wins over the speculative shift of a younger branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (mispredict) begin
      ghr <= ghr_repair;
    end else if (bp.branch_en_F && !bp.stall_F) begin
      ghr <= ghr_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp.branch_count     <= '0;
      bp.mispredict_count <= '0;
    end else if (bp.branch_en_EX) begin
      bp.branch_count <= bp.branch_count + 32'd1;
      if (mispredict) bp.mispredict_count <= bp.mispredict_count + 32'd1;
    end
  end

  assign bp.BP_decision_F = pred_f;
  assign bp.ghr_snap_F    = ghr;
  assign bp.mispredict_EX = mispredict;

endmodule

// File: tb/tb_tournament_bp.sv
// Directed bench: bimodal, gshare and tournament instances driven side by side.
module tb_tournament_bp;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic       dec;
  logic [3:0] snap;

  tournament_bp_if #(.HIST_BITS(8)) if0 ();
  tournament_bp_if #(.HIST_BITS(4)) if1 ();
  tournament_bp_if #(.HIST_BITS(4)) if2 ();

  tournament_bp #(.MODE(0), .INDEX_BITS(8), .HIST_BITS(8)) u0 (.clk(clk), .rst(rst), .bp(if0));
  tournament_bp #(.MODE(1), .INDEX_BITS(8), .HIST_BITS(4)) u1 (.clk(clk), .rst(rst), .bp(if1));
  tournament_bp #(.MODE(2), .INDEX_BITS(8), .HIST_BITS(4)) u2 (.clk(clk), .rst(rst), .bp(if2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_f0(input logic en, input logic [31:0] pc, input logic stall);
    if0.branch_en_F = en; if0.PC_F = pc; if0.stall_F = stall;
  endtask
  task automatic set_f1(input logic en, input logic [31:0] pc, input logic stall);
    if1.branch_en_F = en; if1.PC_F = pc; if1.stall_F = stall;
  endtask
  task automatic set_f2(input logic en, input logic [31:0] pc, input logic stall);
    if2.branch_en_F = en; if2.PC_F = pc; if2.stall_F = stall;
  endtask

  task automatic set_ex0(input logic en, input logic [31:0] pc, input logic res,
                         input logic d, input logic [7:0] s);
    if0.branch_en_EX = en; if0.PC_EX = pc; if0.branch_result = res;
    if0.BP_decision_EX = d; if0.ghr_snap_EX = s;
  endtask
  task automatic set_ex1(input logic en, input logic [31:0] pc, input logic res,
                         input logic d, input logic [3:0] s);
    if1.branch_en_EX = en; if1.PC_EX = pc; if1.branch_result = res;
    if1.BP_decision_EX = d; if1.ghr_snap_EX = s;
  endtask
  task automatic set_ex2(input logic en, input logic [31:0] pc, input logic res,
                         input logic d, input logic [3:0] s);
    if2.branch_en_EX = en; if2.PC_EX = pc; if2.branch_result = res;
    if2.BP_decision_EX = d; if2.ghr_snap_EX = s;
  endtask

  initial begin
    rst = 1'b1;
    set_f0(1'b1, 32'h100, 1'b1); set_ex0(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    set_f1(1'b0, 32'h0, 1'b1);   set_ex1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    set_f2(1'b0, 32'h0, 1'b1);   set_ex2(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    #1;
    check("rst_decision_gated", 32'(if0.BP_decision_F), 32'd0);
    tick; tick;
    rst = 1'b0;
    #1;
    check("m0_reset_predict", 32'(if0.BP_decision_F), 32'd0);
    check("m0_reset_ghr", 32'(if0.ghr_snap_F), 32'h00);
    check("m0_reset_bcount", if0.branch_count, 32'd0);
    check("m0_reset_ctr", 32'(u0.g_bim.u_table.mem[64]), 32'd1);
    check("m2_reset_chooser", 32'(u2.g_cho.u_table.mem[64]), 32'd2);

    // MODE 0: first taken update, mispredicted; fetch sees the pre-update value
    set_ex0(1'b1, 32'h100, 1'b1, 1'b0, 8'h00);
    #1;
    check("m0_mispredict_comb", 32'(if0.mispredict_EX), 32'd1);
    check("m0_same_cycle_read", 32'(if0.BP_decision_F), 32'd0);
    tick;
    set_ex0(1'b1, 32'h100, 1'b1, 1'b1, 8'h00);
    #1;
    check("m0_no_mispredict_comb", 32'(if0.mispredict_EX), 32'd0);
    check("m0_ghr_repair", 32'(if0.ghr_snap_F), 32'h01);
    tick;
    check("m0_two_taken_predict", 32'(if0.BP_decision_F), 32'd1);
    check("m0_bcount2", if0.branch_count, 32'd2);
    check("m0_mcount1", if0.mispredict_count, 32'd1);
    set_f0(1'b0, 32'h100, 1'b1);
    #1;
    check("m0_branch_en_gate", 32'(if0.BP_decision_F), 32'd0);
    set_f0(1'b1, 32'h100, 1'b1);
    tick; tick; tick;
    check("m0_sat_high", 32'(u0.g_bim.u_table.mem[64]), 32'd3);
    set_ex0(1'b1, 32'h100, 1'b0, 1'b1, 8'h00);
    tick;
    check("m0_5t1n_ctr", 32'(u0.g_bim.u_table.mem[64]), 32'd2);
    check("m0_5t1n_predict", 32'(if0.BP_decision_F), 32'd1);
    check("m0_ghr_repair_nt", 32'(if0.ghr_snap_F), 32'h00);
    tick;
    set_ex0(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("m0_5t2n_predict", 32'(if0.BP_decision_F), 32'd0);
    check("m0_bcount7", if0.branch_count, 32'd7);
    check("m0_mcount3", if0.mispredict_count, 32'd3);

    // MODE 1: alternating T/N at 0x40, one branch in flight at a time
    for (int k = 0; k < 16; k++) begin
      set_f1(1'b1, 32'h40, 1'b0);
      #1;
      dec  = if1.BP_decision_F;
      snap = if1.ghr_snap_F;
      tick;
      set_f1(1'b0, 32'h40, 1'b1);
      set_ex1(1'b1, 32'h40, (k % 2) == 0, dec, snap);
      #1;
      if (k >= 8) check("m1_alt_no_mispredict", 32'(if1.mispredict_EX), 32'd0);
      tick;
      set_ex1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    end
    check("m1_alt_bcount", if1.branch_count, 32'd16);
    check("m1_alt_mcount", if1.mispredict_count, 32'd3);

    // MODE 1: same-cycle speculative shift and mispredict repair
    set_ex1(1'b1, 32'h200, 1'b1, 1'b1, 4'b0011);
    tick;
    set_ex1(1'b1, 32'h300, 1'b1, 1'b0, 4'b0001);
    tick;
    check("m1_ghr_setup", 32'(if1.ghr_snap_F), 32'h3);
    set_f1(1'b1, 32'h200, 1'b0);
    set_ex1(1'b1, 32'h300, 1'b1, 1'b0, 4'b0000);
    #1;
    check("m1_gshare_taken", 32'(if1.BP_decision_F), 32'd1);
    tick;
    check("m1_repair_overrides", 32'(if1.ghr_snap_F), 32'h1);
    set_ex1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    #1;
    check("m1_gshare_other_hist", 32'(if1.BP_decision_F), 32'd0);
    tick;
    check("m1_spec_shift", 32'(if1.ghr_snap_F), 32'h2);
    set_f1(1'b1, 32'h200, 1'b1);
    tick;
    check("m1_stall_holds", 32'(if1.ghr_snap_F), 32'h2);
    set_f1(1'b0, 32'h0, 1'b1);

    // MODE 2: chooser training and selection
    set_ex2(1'b1, 32'h100, 1'b1, 1'b1, 4'h1);
    tick;
    set_f2(1'b1, 32'h104, 1'b1);
    set_ex2(1'b1, 32'h104, 1'b1, 1'b1, 4'h0);
    #1;
    check("m2_select_gshare_pre", 32'(if2.BP_decision_F), 32'd1);
    tick;
    check("m2_chooser_inc", 32'(u2.g_cho.u_table.mem[65]), 32'd3);
    set_ex2(1'b1, 32'h100, 1'b1, 1'b1, 4'h1);
    tick;
    check("m2_chooser_agree", 32'(u2.g_cho.u_table.mem[64]), 32'd2);
    set_ex2(1'b1, 32'h100, 1'b1, 1'b1, 4'h2);
    tick;
    check("m2_chooser_dec", 32'(u2.g_cho.u_table.mem[64]), 32'd1);
    set_ex2(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
    set_f2(1'b1, 32'h100, 1'b1);
    #1;
    check("m2_select_bimodal", 32'(if2.BP_decision_F), 32'd1);
    set_f2(1'b1, 32'h108, 1'b1);
    #1;
    check("m2_select_gshare", 32'(if2.BP_decision_F), 32'd1);
    check("m2_ghr_untouched", 32'(if2.ghr_snap_F), 32'h0);

    // Mid-sequence reset between edges, with an update in flight
    set_ex0(1'b1, 32'h100, 1'b1, 1'b0, 8'h05);
    set_f2(1'b1, 32'h100, 1'b1);
    tick;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_bcount", if0.branch_count, 32'd0);
    check("rst_mid_mcount", if0.mispredict_count, 32'd0);
    check("rst_mid_ghr0", 32'(if0.ghr_snap_F), 32'h00);
    check("rst_mid_ghr1", 32'(if1.ghr_snap_F), 32'h0);
    check("rst_mid_ctr0", 32'(u0.g_bim.u_table.mem[64]), 32'd1);
    check("rst_mid_chooser", 32'(u2.g_cho.u_table.mem[64]), 32'd2);
    check("rst_mid_decision", 32'(if2.BP_decision_F), 32'd0);
    tick;
    check("rst_ignores_update", if0.branch_count, 32'd0);
    rst = 1'b0;
    set_ex0(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_bp.md
TOURNAMENT_BP -- requirements
Module: tournament_bp

Interface
REQ-001 SHALL have parameter MODE, default 2, selecting the predictor: 0=bimodal, 1=gshare, 2=tournament (bimodal+gshare+chooser).
REQ-002 SHALL have parameter INDEX_BITS, default 8, giving the log2 of entries per counter table.
REQ-003 SHALL have parameter HIST_BITS, default 8, giving global history length, legal range 1..INDEX_BITS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port branch_en_F, input, 1 bit: the fetched instruction is a conditional branch.
REQ-007 SHALL have port stall_F, input, 1 bit: fetch is stalled this cycle.
REQ-008 SHALL have port PC_F, input, 32 bits: fetch PC.
REQ-009 SHALL have port BP_decision_F, output, 1 bit: predicted taken.
REQ-010 SHALL have port ghr_snap_F, output, HIST_BITS wide: GHR value used for the prediction, piped to EX by the caller.
REQ-011 SHALL have port branch_en_EX, input, 1 bit: a resolved branch is in EX.
REQ-012 SHALL have port PC_EX, input, 32 bits: PC of the resolved branch.
REQ-013 SHALL have port branch_result, input, 1 bit: actual outcome, 1=taken.
REQ-014 SHALL have port BP_decision_EX, input, 1 bit: the prediction that was made for this branch.
REQ-015 SHALL have port ghr_snap_EX, input, HIST_BITS wide: the piped ghr_snap_F of this branch.
REQ-016 SHALL have port mispredict_EX, output, 1 bit: combinational, branch_en_EX && (branch_result != BP_decision_EX).
REQ-017 SHALL have ports branch_count and mispredict_count, output, 32 bits each: performance counters.

Function
REQ-018 SHALL form bimodal index = PC[INDEX_BITS+1:2], and gshare index = PC[INDEX_BITS+1:2] XOR zero-extended history.
REQ-019 SHALL use the live GHR for fetch indexing and ghr_snap_EX for EX indexing.
REQ-020 SHALL hold every table entry as a 2-bit saturating counter: predict taken iff bit[1]=1; increment saturates at 3; decrement saturates at 0.
REQ-021 SHALL make BP_decision_F combinational from PC_F and the current tables, and force it to 0 when branch_en_F=0.
REQ-022 SHALL in MODE 2 select the gshare prediction when the chooser counter at the bimodal index has bit[1]=1, and the bimodal prediction otherwise.
REQ-023 SHALL on a clock edge with branch_en_EX=1 move the active component counter(s) at their EX indices toward branch_result; in MODE 2 both components update.
REQ-024 SHALL in MODE 2 update the chooser only when the two component predictions at EX differ, incrementing if gshare was correct and decrementing otherwise.
REQ-025 SHALL on an edge with branch_en_F=1 and stall_F=0 shift the GHR speculatively: GHR <= {GHR[HIST_BITS-2:0], BP_decision_F}.
REQ-026 SHALL on an edge with mispredict_EX=1 repair the GHR to {ghr_snap_EX[HIST_BITS-2:0], branch_result}; the repair overrides any same-cycle speculative shift.
REQ-027 SHALL apply table writes at the clock edge, so a same-cycle fetch read of the entry being written returns the pre-update value.
REQ-028 SHALL on each branch_en_EX edge increment branch_count, and also mispredict_count when mispredict_EX=1; both wrap modulo 2^32.
REQ-029 SHALL in MODE 0 and MODE 1 leave the unused tables unimplemented and produce no behaviour from them.

Reset
REQ-030 SHALL on rst=1, immediately and independent of clk, set all component counters to 2'b01 (weakly not-taken), all chooser counters to 2'b10 (weakly gshare), and GHR, branch_count and mispredict_count to 0.
REQ-031 SHALL hold BP_decision_F at 0 while rst=1, and ignore any update in flight when rst asserts mid-operation.

Structure
REQ-032 SHALL place the MODE encodings, the counter reset constants and a saturating-update function in shared package bp_pkg.
REQ-033 SHALL implement each table as sub-module bp_counter_table, instantiated once per table, with two combinational read ports (fetch and EX), one write port and asynchronous reset.

Verification
REQ-034 SHALL cover: after reset, MODE 0, PC_F=0x100 with branch_en_F=1 -> BP_decision_F=0; after two taken updates at PC_EX=0x100 -> BP_decision_F=1.
REQ-035 SHALL cover: 5 taken updates then 1 not-taken update at the same PC -> counter reads 2 and prediction stays taken.
REQ-036 SHALL cover: MODE 1, HIST_BITS=4, alternating T/N pattern at PC 0x40 -> zero mispredicts after warm-up of 8 branches.
REQ-037 SHALL cover: speculative shift with GHR=4'b0011 and BP_decision_F=1, plus same-cycle mispredict with ghr_snap_EX=4'b0000 and branch_result=1 -> GHR=4'b0001 after the edge.
REQ-038 SHALL cover: MODE 2, components disagree and gshare is correct -> chooser goes from 2 to 3; components agree -> chooser unchanged.
REQ-039 SHALL cover: rst asserted mid-sequence, between edges -> all counters are 0 and GHR is 0 before the next clk edge.
